// File: rtl/pixie_fb_pkg.sv
// Shared definitions for the Pixie framebuffer arbiter slice.
// Holds the framebuffer geometry, the read-owner tag and the clear FSM states.
package pixie_fb_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int FB_DATA_W = 8;
  localparam int FB_DEPTH  = 1024;

  // Records who issued the RAM read in the previous cycle, so the returning
  // byte (one cycle of RAM latency) can be steered to the right consumer.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/pixie_fb_arbiter_if.sv
// Bundle of every signal between the framebuffer arbiter, its three users
// and the single-port framebuffer RAM.
//   slave  : the arbiter side (takes requests and ram_rdata, drives grants,
//            returned data and the RAM port)
//   master : the environment side (display back end, CPU/DMA, clear control
//            and the RAM itself)
interface pixie_fb_arbiter_if;
  import pixie_fb_pkg::*;

  logic                 disp_rd_en;
  logic [FB_ADDR_W-1:0] disp_addr;
  logic [FB_DATA_W-1:0] disp_data;

  logic                 cpu_wr_req;
  logic [FB_ADDR_W-1:0] cpu_wr_addr;
  logic [FB_DATA_W-1:0] cpu_wr_data;
  logic                 cpu_wr_ack;

  logic                 cpu_rd_req;
  logic [FB_ADDR_W-1:0] cpu_rd_addr;
  logic                 cpu_rd_ack;
  logic [FB_DATA_W-1:0] cpu_rd_data;
  logic                 cpu_rd_valid;

  logic                 clr_start;
  logic [FB_DATA_W-1:0] clr_data;
  logic                 clr_busy;
  logic                 clr_done;

  logic [FB_ADDR_W-1:0] ram_addr;
  logic [FB_DATA_W-1:0] ram_wdata;
  logic                 ram_we;
  logic [FB_DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_rd_en, disp_addr,
    output disp_data,
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    output cpu_wr_ack,
    input  cpu_rd_req, cpu_rd_addr,
    output cpu_rd_ack, cpu_rd_data, cpu_rd_valid,
    input  clr_start, clr_data,
    output clr_busy, clr_done,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output disp_rd_en, disp_addr,
    input  disp_data,
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    input  cpu_wr_ack,
    output cpu_rd_req, cpu_rd_addr,
    input  cpu_rd_ack, cpu_rd_data, cpu_rd_valid,
    output clr_start, clr_data,
    input  clr_busy, clr_done,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/pixie_fb_clear_seq.sv
// Clear-screen sequencer: sweeps every framebuffer byte with a fill value.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_start    : start a sweep (ignored while a sweep runs)
//   i_fill     : fill byte, latched together with i_start
//   i_grant    : the arbiter let this cycle's write through
//   o_req      : a write is wanted this cycle
//   o_addr     : address of the pending write (the sweep counter)
//   o_data     : fill byte of the pending write
//   o_busy     : high for the whole sweep
//   o_done     : one-cycle pulse after the last write
module pixie_fb_clear_seq
  import pixie_fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [FB_DATA_W-1:0] i_fill,
  input  logic                 i_grant,
  output logic                 o_req,
  output logic [FB_ADDR_W-1:0] o_addr,
  output logic [FB_DATA_W-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_DEPTH - 1);

  clr_state_e           r_state;
  clr_state_e           w_stateNext;
  logic [FB_ADDR_W-1:0] r_cnt;
  logic [FB_ADDR_W-1:0] w_cntNext;
  logic [FB_DATA_W-1:0] r_fill;
  logic [FB_DATA_W-1:0] w_fillNext;
  logic                 r_done;
  logic                 w_doneNext;

  // State, counter, fill byte and done pulse all move together on the clock;
  // reset drops any sweep in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_fill  <= w_fillNext;
      r_done  <= w_doneNext;
    end
  end

  // The counter only advances on a granted write, so display fetches simply
  // stretch the sweep. The write to the last address ends it; the counter
  // never wraps.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_fillNext  = r_fill;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_stateNext = CLEAR;
          w_cntNext   = '0;
          w_fillNext  = i_fill;
        end
      end
      CLEAR: begin
        if (i_grant) begin
          if (r_cnt == LAST_ADDR) begin
            w_stateNext = IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_cntNext = r_cnt + FB_ADDR_W'(1);
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign o_req  = (r_state == CLEAR);
  assign o_busy = (r_state == CLEAR);
  assign o_addr = r_cnt;
  assign o_data = r_fill;
  assign o_done = r_done;

endmodule

// File: rtl/pixie_fb_arbiter.sv
// Arbiter for the single-port 1024x8 Pixie framebuffer RAM.
// Per-cycle priority: display fetch, clear sweep, CPU write, CPU read.
// Display fetches always return on the next cycle, so the raster is never
// disturbed; everything else uses the leftover cycles.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   fb         : slave side of pixie_fb_arbiter_if (display fetch, CPU write
//                and read handshakes, clear control, RAM port)
module pixie_fb_arbiter
  import pixie_fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pixie_fb_arbiter_if.slave fb
);

  logic                 w_clrReq;
  logic [FB_ADDR_W-1:0] w_clrAddr;
  logic [FB_DATA_W-1:0] w_clrData;
  logic                 w_clrBusy;
  logic                 w_clrDone;

  logic                 w_grantDisp;
  logic                 w_grantClr;
  logic                 w_grantWr;
  logic                 w_grantRd;

  owner_e               r_tag;
  owner_e               w_tagNext;
  logic [FB_DATA_W-1:0] r_dispHold;
  logic [FB_DATA_W-1:0] r_cpuRdData;
  logic                 r_cpuRdValid;

  pixie_fb_clear_seq u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .i_start (fb.clr_start),
    .i_fill  (fb.clr_data),
    .i_grant (w_grantClr),
    .o_req   (w_clrReq),
    .o_addr  (w_clrAddr),
    .o_data  (w_clrData),
    .o_busy  (w_clrBusy),
    .o_done  (w_clrDone)
  );

  // Fixed-priority grant. CPU traffic is held off for the whole sweep, not
  // just the cycles the sweep actually writes, so a clear is never split.
  always_comb begin
    w_grantDisp = 1'b0;
    w_grantClr  = 1'b0;
    w_grantWr   = 1'b0;
    w_grantRd   = 1'b0;
    if (fb.disp_rd_en) begin
      w_grantDisp = 1'b1;
    end else if (w_clrBusy) begin
      w_grantClr = w_clrReq;
    end else if (fb.cpu_wr_req) begin
      w_grantWr = 1'b1;
    end else if (fb.cpu_rd_req) begin
      w_grantRd = 1'b1;
    end
  end

  // RAM port follows the grant combinationally; an idle cycle parks at 0.
  always_comb begin
    fb.ram_addr  = '0;
    fb.ram_wdata = '0;
    fb.ram_we    = 1'b0;
    if (w_grantDisp) begin
      fb.ram_addr = fb.disp_addr;
    end else if (w_grantClr) begin
      fb.ram_addr  = w_clrAddr;
      fb.ram_wdata = w_clrData;
      fb.ram_we    = 1'b1;
    end else if (w_grantWr) begin
      fb.ram_addr  = fb.cpu_wr_addr;
      fb.ram_wdata = fb.cpu_wr_data;
      fb.ram_we    = 1'b1;
    end else if (w_grantRd) begin
      fb.ram_addr = fb.cpu_rd_addr;
    end
  end

  // Tag the read issued this cycle so next cycle's ram_rdata goes to its owner.
  always_comb begin
    w_tagNext = NONE;
    if (w_grantDisp) begin
      w_tagNext = DISP;
    end else if (w_grantRd) begin
      w_tagNext = CPU;
    end
  end

  // Owner tag plus the display hold register; clearing the tag on reset is
  // also what cancels a CPU read that is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag      <= NONE;
      r_dispHold <= '0;
    end else begin
      r_tag <= w_tagNext;
      if (r_tag == DISP) begin
        r_dispHold <= fb.ram_rdata;
      end
    end
  end

  // CPU read return: one register stage after the RAM, giving ack-to-valid
  // of two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpuRdData  <= '0;
      r_cpuRdValid <= 1'b0;
    end else begin
      r_cpuRdValid <= (r_tag == CPU);
      if (r_tag == CPU) begin
        r_cpuRdData <= fb.ram_rdata;
      end
    end
  end

  // Pass the RAM output straight through in the return cycle so the display
  // sees its byte at T+1, then keep showing it from the hold register.
  assign fb.disp_data    = (r_tag == DISP) ? fb.ram_rdata : r_dispHold;
  assign fb.cpu_wr_ack   = w_grantWr;
  assign fb.cpu_rd_ack   = w_grantRd;
  assign fb.cpu_rd_data  = r_cpuRdData;
  assign fb.cpu_rd_valid = r_cpuRdValid;
  assign fb.clr_busy     = w_clrBusy;
  assign fb.clr_done     = w_clrDone;

endmodule

// File: tb/tb_pixie_fb_arbiter.sv
// Self-checking bench for pixie_fb_arbiter. The bench owns the 1024x8 RAM
// (synchronous read, one-cycle latency). Directed stimulus pushes expected
// display bytes and CPU read results into queues; a negedge monitor pops and
// compares whenever the DUT returns data.
module tb_pixie_fb_arbiter;
  import pixie_fb_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rdExp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic doInit = 1'b0;
  logic rstQ = 1'b1;
  logic dispPend = 1'b0;
  int   cycleCnt = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:1023];
  logic [7:0] dispQ [$];
  rdExp_t     rdQ [$];
  logic [7:0] lastDispExp = 8'h00;

  pixie_fb_arbiter_if bus ();

  pixie_fb_arbiter dut (
    .clk   (clk),
    .reset (rst),
    .fb    (bus)
  );

  always #5 clk = ~clk;

  // Initial RAM contents; address 0x005 carries a recognisable byte.
  function automatic logic [7:0] initPattern(input logic [9:0] a);
    if (a == 10'h005) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  // Expected readback after the clear test (mode 0) or the aborted clear (mode 1).
  function automatic logic [7:0] expectedByte(input int mode, input logic [9:0] a);
    if (mode == 0) return (a == 10'h123) ? 8'h77 : 8'h00;
    return (a < 10'h200) ? 8'h11 : initPattern(a);
  endfunction

  // Framebuffer RAM model: read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (doInit) begin
      for (int i = 0; i < 1024; i++) mem[i] <= initPattern(10'(i));
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    rstQ     <= rst;
    dispPend <= bus.disp_rd_en && !rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pushRead(input logic [7:0] data);
    rdExp_t e;
    e.data = data;
    e.cyc  = cycleCnt + 2;
    rdQ.push_back(e);
  endtask

  // Single CPU read; expected byte queued at the ack.
  task automatic applyStimulusRead(input logic [9:0] a, input logic [7:0] exp, input int maxWait);
    int waited;
    waited = 0;
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_rd_addr = a;
    @(negedge clk);
    while (!bus.cpu_rd_ack && waited < maxWait) begin
      tick;
      @(negedge clk);
      waited++;
    end
    checkOutput("rdAckWithinBound", bus.cpu_rd_ack, 1);
    if (bus.cpu_rd_ack) pushRead(exp);
    tick;
    bus.cpu_rd_req = 1'b0;
  endtask

  // Back-to-back reads of the whole framebuffer, one new request per ack.
  task automatic applyStimulusReadAll(input int mode);
    int a;
    int guard;
    a = 0;
    guard = 0;
    bus.cpu_rd_req = 1'b1;
    while (a < 1024 && guard < 3000) begin
      bus.cpu_rd_addr = 10'(a);
      @(negedge clk);
      if (bus.cpu_rd_ack) begin
        pushRead(expectedByte(mode, 10'(a)));
        a++;
      end
      tick;
      guard++;
    end
    bus.cpu_rd_req = 1'b0;
    checkOutput("readAllCompleted", a, 1024);
    repeat (4) tick;
  endtask

  // Monitor: display return and hold, CPU read return with latency.
  always @(negedge clk) begin
    rdExp_t e;
    if (rst || rstQ) begin
      lastDispExp = 8'h00;
    end else begin
      if (dispPend) begin
        checkOutput("dispQueued", dispQ.size() > 0, 1);
        if (dispQ.size() > 0) begin
          lastDispExp = dispQ.pop_front();
          checkOutput("dispData", bus.disp_data, lastDispExp);
        end
      end else begin
        checkOutput("dispHold", bus.disp_data, lastDispExp);
      end
      if (bus.cpu_rd_valid) begin
        checkOutput("rdQueued", rdQ.size() > 0, 1);
        if (rdQ.size() > 0) begin
          e = rdQ.pop_front();
          checkOutput("rdData", bus.cpu_rd_data, e.data);
          checkOutput("rdLatency", cycleCnt, e.cyc);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: run exceeded 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCycle;
    int ackCycle;
    int busyCycles;
    int doneCount;
    int ackInBusy;
    int fetchN;

    bus.disp_rd_en  = 1'b0;
    bus.disp_addr   = '0;
    bus.cpu_wr_req  = 1'b0;
    bus.cpu_wr_addr = '0;
    bus.cpu_wr_data = '0;
    bus.cpu_rd_req  = 1'b0;
    bus.cpu_rd_addr = '0;
    bus.clr_start   = 1'b0;
    bus.clr_data    = '0;

    // Reset and RAM preload.
    rst = 1'b1;
    doInit = 1'b1;
    tick;
    doInit = 1'b0;
    tick;
    @(negedge clk);
    checkOutput("rstDispData", bus.disp_data, 0);
    checkOutput("rstCpuRdData", bus.cpu_rd_data, 0);
    checkOutput("rstWrAck", bus.cpu_wr_ack, 0);
    checkOutput("rstRdAck", bus.cpu_rd_ack, 0);
    checkOutput("rstRdValid", bus.cpu_rd_valid, 0);
    checkOutput("rstClrBusy", bus.clr_busy, 0);
    checkOutput("rstClrDone", bus.clr_done, 0);
    checkOutput("rstRamWe", bus.ram_we, 0);
    checkOutput("rstRamAddr", bus.ram_addr, 0);
    tick;
    rst = 1'b0;
    tick;

    // Display fetch collides with a CPU write to 0x005.
    $display("[TB] display fetch with concurrent write");
    bus.disp_rd_en  = 1'b1;
    bus.disp_addr   = 10'h005;
    dispQ.push_back(8'h3C);
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_addr = 10'h005;
    bus.cpu_wr_data = 8'hFF;
    @(negedge clk);
    checkOutput("t1WrAckBlocked", bus.cpu_wr_ack, 0);
    checkOutput("t1RamWeOnFetch", bus.ram_we, 0);
    tick;
    bus.disp_rd_en = 1'b0;
    @(negedge clk);
    checkOutput("t1WrAck", bus.cpu_wr_ack, 1);
    tick;
    bus.cpu_wr_req = 1'b0;
    applyStimulusRead(10'h005, 8'hFF, 4);
    repeat (3) tick;

    // Simultaneous write and read to 0x10A: write first, read sees new data.
    $display("[TB] simultaneous write and read");
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_addr = 10'h10A;
    bus.cpu_wr_data = 8'hA5;
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_rd_addr = 10'h10A;
    @(negedge clk);
    checkOutput("t2WrAckFirst", bus.cpu_wr_ack, 1);
    checkOutput("t2RdAckHeld", bus.cpu_rd_ack, 0);
    tick;
    bus.cpu_wr_req = 1'b0;
    @(negedge clk);
    checkOutput("t2RdAckNext", bus.cpu_rd_ack, 1);
    if (bus.cpu_rd_ack) pushRead(8'hA5);
    tick;
    bus.cpu_rd_req = 1'b0;
    repeat (4) tick;

    // Clear to 0x00 with a fetch every 8 cycles, a CPU write held through
    // the sweep and a second clr_start (0xEE) in mid-sweep.
    $display("[TB] clear sweep with fetches and held write");
    doneCycle = -1;
    ackCycle = -1;
    busyCycles = 0;
    doneCount = 0;
    ackInBusy = 0;
    fetchN = 0;
    for (int c = 0; c < 1200; c++) begin
      bus.clr_start  = (c == 0) || (c == 500);
      bus.clr_data   = (c == 500) ? 8'hEE : 8'h00;
      bus.disp_rd_en = (c >= 1) && (((c - 1) % 8) == 0);
      if (bus.disp_rd_en) begin
        bus.disp_addr = (fetchN < 100) ? 10'(1023 - fetchN) : 10'h000;
        dispQ.push_back((fetchN < 100) ? initPattern(bus.disp_addr) : 8'h00);
        fetchN++;
      end
      if (c == 2) begin
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_addr = 10'h123;
        bus.cpu_wr_data = 8'h77;
      end
      @(negedge clk);
      if (bus.clr_busy) busyCycles++;
      if (bus.clr_done) begin
        doneCount++;
        doneCycle = c;
      end
      if (bus.cpu_wr_ack) begin
        if (bus.clr_busy) ackInBusy++;
        if (ackCycle < 0) ackCycle = c;
      end
      tick;
      if (ackCycle >= 0) bus.cpu_wr_req = 1'b0;
    end
    bus.clr_start  = 1'b0;
    bus.disp_rd_en = 1'b0;
    bus.cpu_wr_req = 1'b0;
    checkOutput("t3BusyCycles", busyCycles, 1171);
    checkOutput("t3DoneCount", doneCount, 1);
    checkOutput("t3DoneCycle", doneCycle, 1172);
    checkOutput("t3AckWhileBusy", ackInBusy, 0);
    checkOutput("t3AckAfterDone", (doneCycle >= 0) && (ackCycle >= doneCycle) && (ackCycle - doneCycle <= 2), 1);
    applyStimulusReadAll(0);

    // Reset while the sweep is about to reach 0x200.
    $display("[TB] reset mid-clear");
    doInit = 1'b1;
    tick;
    doInit = 1'b0;
    bus.clr_data = 8'h11;
    doneCount = 0;
    for (int c = 0; c < 520; c++) begin
      bus.clr_start = (c == 0);
      rst = (c == 512);
      @(negedge clk);
      if (bus.clr_done) doneCount++;
      if (c == 511) checkOutput("t4BusyBeforeRst", bus.clr_busy, 1);
      if (c == 512) checkOutput("t4AddrAtRst", bus.ram_addr, 10'h1FF);
      if (c == 513) checkOutput("t4BusyAfterRst", bus.clr_busy, 0);
      tick;
    end
    rst = 1'b0;
    checkOutput("t4NoDone", doneCount, 0);
    applyStimulusReadAll(1);

    // A fresh clear starts again from address 0.
    $display("[TB] restart clear after abort");
    bus.clr_data  = 8'h22;
    bus.clr_start = 1'b1;
    @(negedge clk);
    checkOutput("t5BusyAtStart", bus.clr_busy, 0);
    tick;
    bus.clr_start = 1'b0;
    @(negedge clk);
    checkOutput("t5Busy", bus.clr_busy, 1);
    checkOutput("t5RamWe", bus.ram_we, 1);
    checkOutput("t5FirstAddr", bus.ram_addr, 0);
    checkOutput("t5FillData", bus.ram_wdata, 8'h22);
    tick;
    @(negedge clk);
    checkOutput("t5SecondAddr", bus.ram_addr, 1);
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    repeat (3) tick;

    checkOutput("dispQueueDrained", dispQ.size(), 0);
    checkOutput("rdQueueDrained", rdQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
